// File: rtl/booth_pkg.sv
// Shared Booth radix-8 definitions for the encoder and selector units.
// Code layout is {neg, x4, x3, x2, x1}; zero never carries the neg bit.
package booth_pkg;

    localparam int WIDTH    = 24;
    localparam int N_GROUPS = 8;

    typedef logic [4:0] beu_code_t;

    localparam beu_code_t BEU_ZERO = 5'b00000;
    localparam beu_code_t BEU_P1   = 5'b00001;
    localparam beu_code_t BEU_P2   = 5'b00010;
    localparam beu_code_t BEU_P3   = 5'b00100;
    localparam beu_code_t BEU_P4   = 5'b01000;
    localparam beu_code_t BEU_N1   = 5'b10001;
    localparam beu_code_t BEU_N2   = 5'b10010;
    localparam beu_code_t BEU_N3   = 5'b10100;
    localparam beu_code_t BEU_N4   = 5'b11000;

endpackage

// File: rtl/booth_group_encoder.sv
// Combinational radix-8 Booth encoder for one 4-bit overlapping group.
// Group value is -4*g[3] + 2*g[2] + g[1] + g[0].
module booth_group_encoder
    import booth_pkg::*;
(
    input  logic [3:0] grp,
    output beu_code_t  code
);

    // Map the group bits straight to the one-hot magnitude plus sign code.
    always_comb begin
        code = BEU_ZERO;
        unique case (grp)
            4'b0000: code = BEU_ZERO;
            4'b0001: code = BEU_P1;
            4'b0010: code = BEU_P1;
            4'b0011: code = BEU_P2;
            4'b0100: code = BEU_P2;
            4'b0101: code = BEU_P3;
            4'b0110: code = BEU_P3;
            4'b0111: code = BEU_P4;
            4'b1000: code = BEU_N4;
            4'b1001: code = BEU_N3;
            4'b1010: code = BEU_N3;
            4'b1011: code = BEU_N2;
            4'b1100: code = BEU_N2;
            4'b1101: code = BEU_N1;
            4'b1110: code = BEU_N1;
            4'b1111: code = BEU_ZERO;
            default: code = BEU_ZERO;
        endcase
    end

endmodule

// File: rtl/booth_encoder_stream.sv
// Streams the 8 Booth codes of a latched 24-bit multiplier, one per beat.
// Optional BOOTH_PACKED_OUT_EN adds a registered all-groups code vector.
module booth_encoder_stream
    import booth_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output beu_code_t        out_code,
    output logic [2:0]       out_idx,
    output logic             out_last,
    output logic             busy
`ifdef BOOTH_PACKED_OUT_EN
    ,
    output beu_code_t [N_GROUPS-1:0] beu_all,
    output logic                     beu_all_valid
`endif
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [2:0]       cnt;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH:0]   y_ext;
    logic [3:0]       grps [N_GROUPS];
    beu_code_t        cur_code;
    logic             accept;
    logic             xfer;
    logic             last_xfer;

    assign accept    = (state == IDLE) && in_valid;
    assign xfer      = (state == RUN) && out_ready;
    assign last_xfer = xfer && (cnt == 3'd7);

    // Control FSM, group counter and operand latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
            y_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        y_q   <= y;
                        cnt   <= 3'd0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign y_ext = {y_q, 1'b0};

    // Split the latched operand into overlapping 4-bit groups.
    always_comb begin
        for (int i = 0; i < N_GROUPS; i++) begin
            grps[i] = y_ext[3*i +: 4];
        end
    end

    booth_group_encoder u_enc (
        .grp  (grps[cnt]),
        .code (cur_code)
    );

    assign busy      = (state == RUN);
    assign in_ready  = (state == IDLE);
    assign out_valid = busy;
    assign out_idx   = cnt;
    assign out_last  = busy && (cnt == 3'd7);
    assign out_code  = busy ? cur_code : BEU_ZERO;

`ifdef BOOTH_PACKED_OUT_EN
    logic [WIDTH:0] in_ext;
    beu_code_t      all_codes [N_GROUPS];

    assign in_ext = {y, 1'b0};

    for (genvar g = 0; g < N_GROUPS; g++) begin : g_all
        booth_group_encoder u_enc_all (
            .grp  (in_ext[3*g +: 4]),
            .code (all_codes[g])
        );
    end

    // Capture every group code at acceptance; valid for the whole run.
    always_ff @(posedge clk) begin
        if (rst) begin
            beu_all       <= '0;
            beu_all_valid <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < N_GROUPS; i++) begin
                beu_all[i] <= all_codes[i];
            end
            beu_all_valid <= 1'b1;
        end else if (last_xfer) begin
            beu_all_valid <= 1'b0;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = accept ^ last_xfer;
`endif

endmodule
